// File: rtl/piso_serializer_if.sv
// Parallel-word handshake plus registered serial output bundle for piso_serializer.
// master = word source / serial consumer side, slave = the serializer itself.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             dout;
  logic             load;
  logic             done;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  dout,
    input  load,
    input  done
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output dout,
    output load,
    output done
  );
endinterface

// File: rtl/piso_serializer.sv
// LSB-first parallel-to-serial converter; bit 0 of a word appears one cycle after accept.
// One-word hold buffer keeps load gapless; din_ready drops while the hold buffer is occupied.
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic              clk,
  input logic              rst,
  piso_serializer_if.slave bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_hold_nxt;
  logic             r_hold_full;
  logic             w_hold_full_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dout;
  logic             w_dout_nxt;
  logic             r_load;
  logic             w_load_nxt;
  logic             r_done;
  logic             w_done_nxt;

  logic             w_din_ready;
  logic             w_accept;
  logic             w_last;

  // rst gates ready combinationally so nothing is accepted while reset is held
  assign w_din_ready = !r_hold_full && !rst;
  assign w_accept    = bus.din_valid && w_din_ready;
  assign w_last      = (r_cnt == LAST_CNT);

  always_comb begin
    w_state_nxt     = r_state;
    w_sreg_nxt      = r_sreg;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_cnt_nxt       = r_cnt;
    w_dout_nxt      = 1'b0;
    w_load_nxt      = 1'b0;
    w_done_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_sreg_nxt  = bus.din;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        w_dout_nxt = r_sreg[0];
        w_load_nxt = 1'b1;
        w_sreg_nxt = r_sreg >> 1;
        w_cnt_nxt  = r_cnt + CNT_W'(1);

        if (w_last) begin
          w_done_nxt = 1'b1;
          // next word: held word first, then a same-cycle bypass, else go idle
          if (r_hold_full) begin
            w_sreg_nxt      = r_hold;
            w_hold_full_nxt = 1'b0;
            w_cnt_nxt       = '0;
          end else if (w_accept) begin
            w_sreg_nxt = bus.din;
            w_cnt_nxt  = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_accept) begin
          w_hold_nxt      = bus.din;
          w_hold_full_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sreg      <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
      r_dout      <= 1'b0;
      r_load      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sreg      <= w_sreg_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dout      <= w_dout_nxt;
      r_load      <= w_load_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign bus.din_ready = w_din_ready;
  assign bus.dout      = r_dout;
  assign bus.load      = r_load;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: bit-queue reference model, downstream deserializer scoreboard,
// and directed literal scenarios (single word, back-to-back, bypass, backpressure, reset, idle).
module tb_piso_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bus_if ();
  piso_serializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending serial bits tagged with an end-of-word flag.
  // Each edge emits one bit (if any), then appends the accepted word's bits.
  logic [1:0]   bq[$];
  logic [W-1:0] acc_q[$];
  logic         exp_dout = 1'b0;
  logic         exp_load = 1'b0;
  logic         exp_done = 1'b0;
  logic         m_acc;
  logic [1:0]   m_e;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        bq.delete();
        acc_q.delete();
        exp_dout = 1'b0;
        exp_load = 1'b0;
        exp_done = 1'b0;
      end else begin
        m_acc = bus_if.din_valid && (bq.size() <= W);
        if (bq.size() != 0) begin
          m_e      = bq.pop_front();
          exp_dout = m_e[0];
          exp_done = m_e[1];
          exp_load = 1'b1;
        end else begin
          exp_dout = 1'b0;
          exp_done = 1'b0;
          exp_load = 1'b0;
        end
        if (m_acc) begin
          for (int i = 0; i < W; i++) bq.push_back({(i == W - 1), bus_if.din[i]});
          acc_q.push_back(bus_if.din);
        end
      end
    end
  end

  // Compare on every falling edge; downstream deserializer rebuilds words from dout/load.
  logic [W-1:0] ds_word = '0;
  int           ds_cnt  = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("dout", bus_if.dout, exp_dout);
      chk("load", bus_if.load, exp_load);
      chk("done", bus_if.done, exp_done);
      chk("din_ready", bus_if.din_ready, (!rst && (bq.size() <= W)));
      if (rst) begin
        ds_cnt = 0;
      end else if (bus_if.load) begin
        ds_word[ds_cnt] = bus_if.dout;
        ds_cnt++;
        if (ds_cnt == W) begin
          ds_cnt = 0;
          if (acc_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL deser_word: got %0h, expected no word pending (t=%0t)", ds_word, $time);
          end else begin
            chk("deser_word", ds_word, acc_q.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [W-1:0] d);
    bus_if.din_valid = v;
    bus_if.din       = d;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0]  pat;
  logic [17:0]   v_load, v_dout, v_done, v_rdy;
  logic [W-1:0]  word;
  int            n_acc;

  initial begin
    rst              = 1'b1;
    bus_if.din_valid = 1'b0;
    bus_if.din       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din_ready", bus_if.din_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", bus_if.din_ready, 1'b1);

    // idle with valid low
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, W'($urandom));
      chk("idle_load", bus_if.load, 1'b0);
      chk("idle_dout", bus_if.dout, 1'b0);
      chk("idle_done", bus_if.done, 1'b0);
      chk("idle_ready", bus_if.din_ready, 1'b1);
    end

    // single word A5
    pat = 8'hA5;
    cyc(1'b1, pat);
    chk("t1_load_at_accept", bus_if.load, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, W'($urandom));
      chk("t1_load", bus_if.load, (k < 8));
      chk("t1_dout", bus_if.dout, (k < 8) ? pat[k % 8] : 1'b0);
      chk("t1_done", bus_if.done, (k == 7));
    end

    // back-to-back 01 then FF into hold
    v_load = 18'h0FFFF;
    v_dout = 18'h0FF01;
    v_done = 18'h08080;
    v_rdy  = 18'h3FF81;
    cyc(1'b1, 8'h01);
    for (int k = 0; k < 18; k++) begin
      cyc((k == 1), (k == 1) ? 8'hFF : W'($urandom));
      chk("t2_load", bus_if.load, v_load[k]);
      chk("t2_dout", bus_if.dout, v_dout[k]);
      chk("t2_done", bus_if.done, v_done[k]);
      chk("t2_ready", bus_if.din_ready, v_rdy[k]);
    end

    // bypass on last bit: 00 then 80 presented exactly at the last-bit edge
    v_dout = 18'h08000;
    cyc(1'b1, 8'h00);
    for (int k = 0; k < 18; k++) begin
      cyc((k == 7), (k == 7) ? 8'h80 : W'($urandom));
      chk("t3_load", bus_if.load, v_load[k]);
      chk("t3_dout", bus_if.dout, v_dout[k]);
      chk("t3_done", bus_if.done, v_done[k]);
    end

    // backpressure: valid always high with a fresh word every cycle
    n_acc = 0;
    for (int c = 0; c < 200; c++) begin
      if (c >= 40 && c < 120 && bus_if.din_ready) n_acc++;
      cyc(1'b1, W'($urandom));
    end
    chk("bp_accepts_in_80_cycles", n_acc, 10);
    for (int k = 0; k < 20; k++) cyc(1'b0, W'($urandom));

    // random valid pattern
    for (int c = 0; c < 600; c++) cyc(($urandom_range(0, 2) == 0), W'($urandom));
    for (int k = 0; k < 20; k++) cyc(1'b0, W'($urandom));

    // reset during bit 3 of 3C with a word in hold
    cyc(1'b1, 8'h3C);
    cyc(1'b1, W'($urandom));
    chk("t5_hold_full_ready", bus_if.din_ready, 1'b0);
    repeat (3) cyc(1'b0, W'($urandom));
    chk("t5_bit3", bus_if.dout, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_load", bus_if.load, 1'b0);
    chk("t5_rst_dout", bus_if.dout, 1'b0);
    chk("t5_rst_done", bus_if.done, 1'b0);
    chk("t5_rst_ready", bus_if.din_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_release_ready", bus_if.din_ready, 1'b1);
    cyc(1'b1, 8'h96);
    word = '0;
    for (int k = 0; k < 9; k++) begin
      cyc(1'b0, W'($urandom));
      chk("t5_load", bus_if.load, (k < 8));
      if (k < 8) word[k] = bus_if.dout;
    end
    chk("t5_word", word, 8'h96);
    for (int k = 0; k < 10; k++) cyc(1'b0, W'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
